// File: rtl/serial_pkg.sv
// Shared types and default framing constants for the serial frame receiver.
package serial_pkg;
  typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_t;

  localparam int         DEF_START_W   = 4;
  localparam logic [3:0] DEF_START_PAT = 4'b0000;
  localparam int         DEF_DATA_W    = 8;
endpackage

// File: rtl/serial_shift_reg.sv
// Serial-in shift register with synchronous parallel load (load wins over shift).
module serial_shift_reg #(
  parameter int               WIDTH     = 4,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             load,
  input  logic             s_in,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] shifted;

  // MSB_FIRST enters at bit 0 and walks up, so the first bit ends in the MSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shifted = s_in;
    end else if (MSB_FIRST) begin : g_msb
      assign shifted = {q[WIDTH-2:0], s_in};
    end else begin : g_lsb
      assign shifted = {s_in, q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       q <= RST_VAL;
    else if (load)  q <= load_val;
    else if (shift) q <= shifted;
  end
endmodule

// File: rtl/serial_frame_rx.sv
// Hunts for a start pattern on a strobed serial line, then deserialises one
// payload word into a single-entry output buffer with overrun reporting.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int                 START_W   = DEF_START_W,
  parameter logic [START_W-1:0] START_PAT = START_W'(DEF_START_PAT),
  parameter int                 DATA_W    = DEF_DATA_W,
  parameter bit                 MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_in,
  input  logic              en,
  output logic [DATA_W-1:0] p_out,
  output logic              p_valid,
  input  logic              p_ready,
  output logic [START_W-1:0] window,
  output logic              busy,
  output logic              overrun
);
  localparam int CW = $clog2(DATA_W + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] payload;
  logic [START_W-1:0] win_nxt;
  logic [DATA_W-1:0] word_nxt;
  logic              hit, done;

  // Next-cycle views of both registers: detection and word capture must
  // include the bit being sampled on this edge.
  generate
    if (START_W == 1) begin : g_win1
      assign win_nxt = s_in;
    end else begin : g_winn
      assign win_nxt = {window[START_W-2:0], s_in};
    end
    if (DATA_W == 1) begin : g_wd1
      assign word_nxt = s_in;
    end else if (MSB_FIRST) begin : g_wdm
      assign word_nxt = {payload[DATA_W-2:0], s_in};
    end else begin : g_wdl
      assign word_nxt = {s_in, payload[DATA_W-1:1]};
    end
  endgenerate

  assign hit  = (state == HUNT) && en && (win_nxt == START_PAT);
  assign done = (state == DATA) && en && (cnt == CW'(DATA_W - 1));

  // Window is frozen during DATA so payload bits can never look like a start.
  serial_shift_reg #(
    .WIDTH(START_W), .MSB_FIRST(1'b1), .RST_VAL(~START_PAT)
  ) u_window (
    .clk(clk), .rst(rst),
    .shift(en && (state == HUNT)),
    .load(done),
    .s_in(s_in),
    .load_val(~START_PAT),
    .q(window)
  );

  serial_shift_reg #(
    .WIDTH(DATA_W), .MSB_FIRST(MSB_FIRST), .RST_VAL('0)
  ) u_payload (
    .clk(clk), .rst(rst),
    .shift(en && (state == DATA)),
    .load(hit),
    .s_in(s_in),
    .load_val('0),
    .q(payload)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= HUNT;
      cnt     <= '0;
      busy    <= 1'b0;
      p_out   <= '0;
      p_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= done && p_valid && !p_ready;
      case (state)
        HUNT: if (hit) begin
          state <= DATA;
          busy  <= 1'b1;
          cnt   <= '0;
        end
        DATA: if (en) begin
          cnt <= cnt + CW'(1);
          if (done) begin
            state <= HUNT;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= HUNT;
          busy  <= 1'b0;
        end
      endcase
      // A handshake on the completing edge frees the slot for the new word.
      if (done && (!p_valid || p_ready)) begin
        p_out   <= word_nxt;
        p_valid <= 1'b1;
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench: default-parameter receiver plus an LSB-first copy on the same line.
module tb_serial_frame_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_in = 1'b0;
  logic       en = 1'b0;
  logic       p_ready = 1'b0;
  logic [7:0] p_out0, p_out1;
  logic       p_valid0, p_valid1, busy0, busy1, ovr0, ovr1;
  logic [3:0] window0, window1;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  serial_frame_rx dut0 (
    .clk(clk), .rst(rst), .s_in(s_in), .en(en),
    .p_out(p_out0), .p_valid(p_valid0), .p_ready(p_ready),
    .window(window0), .busy(busy0), .overrun(ovr0)
  );

  serial_frame_rx #(.MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .s_in(s_in), .en(en),
    .p_out(p_out1), .p_valid(p_valid1), .p_ready(p_ready),
    .window(window1), .busy(busy1), .overrun(ovr1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one strobed bit, then gap idle cycles; returns 1 time unit after an edge.
  task automatic send_bit(input logic b, input int gap);
    s_in = b;
    en   = 1'b1;
    @(posedge clk); #1;
    en   = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_bits(input logic [7:0] w, input int nbits, input int gap);
    for (int i = 7; i > 7 - nbits; i--) send_bit(w[i], gap);
  endtask

  task automatic send_frame(input logic [7:0] w, input int gap);
    send_bits(8'h00, 4, gap);
    send_bits(w, 8, gap);
  endtask

  task automatic consume();
    p_ready = 1'b1;
    @(posedge clk); #1;
    p_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset, asserted mid-cycle with no edge in between
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    chk("win_pre_rst", window0, 4'b1110);
    #2 rst = 1'b0;
    #1;
    chk("rst_window", window0, 4'b1111);
    chk("rst_p_valid", p_valid0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_overrun", ovr0, 1'b0);
    chk("rst_p_out", p_out0, 8'h00);
    @(posedge clk); #1 rst = 1'b1;

    // Basic frame: 1,1,0,0,0,0 then A5
    send_bits(8'b110000_00, 5, 0);
    chk("basic_busy5", busy0, 1'b0);
    send_bit(1'b0, 0);
    chk("basic_busy6", busy0, 1'b1);
    send_bits(8'hA5, 7, 0);
    chk("basic_valid13", p_valid0, 1'b0);
    send_bit(1'b1, 0);
    chk("basic_valid14", p_valid0, 1'b1);
    chk("basic_p_out", p_out0, 8'hA5);
    chk("basic_busy_end", busy0, 1'b0);
    chk("basic_win_reload", window0, 4'b1111);
    repeat (3) @(posedge clk);
    #1 chk("basic_hold_valid", p_valid0, 1'b1);
    chk("basic_hold_p_out", p_out0, 8'hA5);
    consume();
    chk("basic_consumed", p_valid0, 1'b0);

    // Strobe gaps of 3 idle cycles between bits
    send_bit(1'b0, 3);
    chk("gap_window", window0, 4'b1110);
    send_bits(8'h00, 3, 3);
    chk("gap_busy", busy0, 1'b1);
    send_bits(8'hA5, 4, 3);
    chk("gap_busy_mid", busy0, 1'b1);
    send_bits(8'h50, 4, 3);
    chk("gap_p_out", p_out0, 8'hA5);
    chk("gap_valid", p_valid0, 1'b1);
    consume();

    // Overrun: second word dropped while the first is held
    send_frame(8'h3C, 0);
    chk("ovr_first", p_out0, 8'h3C);
    chk("ovr_none_yet", ovr0, 1'b0);
    send_frame(8'hC3, 0);
    chk("ovr_pulse", ovr0, 1'b1);
    chk("ovr_p_out_kept", p_out0, 8'h3C);
    chk("ovr_valid_kept", p_valid0, 1'b1);
    @(posedge clk); #1;
    chk("ovr_pulse_end", ovr0, 1'b0);

    // Handshake on the completing edge: new word replaces, no overrun
    send_bits(8'h00, 4, 0);
    send_bits(8'hC3, 7, 0);
    p_ready = 1'b1;
    send_bit(1'b1, 0);
    p_ready = 1'b0;
    chk("simul_p_out", p_out0, 8'hC3);
    chk("simul_valid", p_valid0, 1'b1);
    chk("simul_ovr", ovr0, 1'b0);
    @(posedge clk); #1;
    chk("simul_ovr_next", ovr0, 1'b0);
    chk("simul_valid_next", p_valid0, 1'b1);
    consume();

    // Zero payload must not retrigger the hunt
    send_frame(8'h00, 0);
    chk("zero_p_out", p_out0, 8'h00);
    chk("zero_valid", p_valid0, 1'b1);
    chk("zero_busy", busy0, 1'b0);
    consume();
    send_frame(8'h81, 0);
    chk("zero_next_p_out", p_out0, 8'h81);
    chk("zero_next_valid", p_valid0, 1'b1);
    consume();

    // LSB-first instance: first bit lands in bit 0
    send_frame(8'h80, 0);
    chk("lsb_p_out", p_out1, 8'h01);
    chk("lsb_valid", p_valid1, 1'b1);
    chk("msb_same_bits", p_out0, 8'h80);
    consume();

    // Reset after 3 payload bits, then a clean frame
    send_bits(8'h00, 4, 0);
    send_bits(8'h5A, 3, 0);
    chk("midrst_busy_pre", busy0, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_valid", p_valid0, 1'b0);
    chk("midrst_window", window0, 4'b1111);
    @(posedge clk); #1 rst = 1'b1;
    send_frame(8'h5A, 0);
    chk("midrst_p_out", p_out0, 8'h5A);
    chk("midrst_valid_after", p_valid0, 1'b1);
    chk("midrst_ovr", ovr0, 1'b0);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
